// File: rtl/seg_scan_capture_pkg.sv
// Shared constants for the 7-segment scan receiver: segment patterns
// ({a,b,c,d,e,f,g} order), special digit codes and the slot FSM encoding.
package seg_scan_capture_pkg;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;

  localparam logic [3:0] CODE_BLANK   = 4'hF;
  localparam logic [3:0] CODE_INVALID = 4'hE;

  typedef enum logic [1:0] {
    SETTLING = 2'd0,
    CAPTURE  = 2'd1,
    HOLD     = 2'd2
  } scan_state_e;

endpackage

// File: rtl/seg_scan_capture_decode.sv
// Combinational 7-segment pattern to digit code decoder; all-off decodes to
// blank, anything unrecognised decodes to the invalid code with a flag.
module seg_decode
  import seg_scan_capture_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] code_o,
  output logic       invalid_o
);

  always_comb begin
    code_o    = CODE_INVALID;
    invalid_o = 1'b0;
    case (seg_i)
      SEG_0:   code_o = 4'd0;
      SEG_1:   code_o = 4'd1;
      SEG_2:   code_o = 4'd2;
      SEG_3:   code_o = 4'd3;
      SEG_4:   code_o = 4'd4;
      SEG_5:   code_o = 4'd5;
      SEG_6:   code_o = 4'd6;
      SEG_7:   code_o = 4'd7;
      SEG_8:   code_o = 4'd8;
      SEG_9:   code_o = 4'd9;
      7'b0:    code_o = CODE_BLANK;
      default: begin
        code_o    = CODE_INVALID;
        invalid_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Receiver for a multiplexed 7-segment scan: synchronises the lines, samples
// each slot once it has settled and publishes complete 4-digit frames.
module seg_scan_capture
  import seg_scan_capture_pkg::*;
#(
  parameter int SETTLE      = 4,
  parameter int SETTLE_BITS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  input  logic       dp,
  input  logic [3:0] pos,
  input  logic       clr_err,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic [3:0] dp_mask,
  output logic       frame_valid,
  output logic       frame_pulse,
  output logic       seg_err
);

  localparam logic [SETTLE_BITS-1:0] SETTLE_MAX  = SETTLE_BITS'(SETTLE);
  localparam logic [SETTLE_BITS-1:0] SETTLE_LAST = SETTLE_BITS'(SETTLE - 1);

  logic [11:0]            sync1_q, v_q, vprev_q;
  logic [SETTLE_BITS-1:0] count_q;
  scan_state_e            state_q;
  logic [15:0]            shadow_q, shadow_d, frame_q;
  logic [3:0]             shadow_dp_q, shadow_dp_d, frame_dp_q;
  logic [3:0]             seen_q, wr_w;
  logic                   valid_q, pulse_q, err_q;

  logic [6:0] seg_w;
  logic       dp_w, changed_w, onehot_w, cap_w, complete_w, invalid_w;
  logic [3:0] pos_w, code_w;

  assign seg_w     = v_q[11:5];
  assign dp_w      = v_q[4];
  assign pos_w     = v_q[3:0];
  assign changed_w = (v_q != vprev_q);
  assign onehot_w  = (pos_w != 4'b0) && ((pos_w & (pos_w - 4'd1)) == 4'b0);

  // The sample is taken on the edge that moves SETTLING into CAPTURE, so the
  // slot contents are written while the lines are known to be stable.
  assign cap_w      = (state_q == SETTLING) && !changed_w && (count_q == SETTLE_LAST) && onehot_w;
  assign complete_w = cap_w && ((seen_q | pos_w) == 4'b1111);

  seg_decode u_decode (
    .seg_i     (seg_w),
    .code_o    (code_w),
    .invalid_o (invalid_w)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slot
      assign wr_w[gi]                = cap_w & pos_w[gi];
      assign shadow_d[gi*4 +: 4]     = wr_w[gi] ? code_w : shadow_q[gi*4 +: 4];
      assign shadow_dp_d[gi]         = wr_w[gi] ? dp_w : shadow_dp_q[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= '0;
      v_q         <= '0;
      vprev_q     <= '0;
      count_q     <= '0;
      state_q     <= SETTLING;
      shadow_q    <= {4{CODE_BLANK}};
      shadow_dp_q <= '0;
      seen_q      <= '0;
      frame_q     <= {4{CODE_BLANK}};
      frame_dp_q  <= '0;
      valid_q     <= 1'b0;
      pulse_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sync1_q <= {a, b, c, d, e, f, g, dp, pos};
      v_q     <= sync1_q;
      vprev_q <= v_q;

      if (changed_w)                count_q <= '0;
      else if (count_q != SETTLE_MAX) count_q <= count_q + 1'b1;

      case (state_q)
        SETTLING: if (!changed_w && count_q == SETTLE_LAST) state_q <= CAPTURE;
        // A change landing in the capture cycle must not strand us in HOLD.
        CAPTURE:  state_q <= changed_w ? SETTLING : HOLD;
        HOLD:     if (changed_w) state_q <= SETTLING;
        default:  state_q <= SETTLING;
      endcase

      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      pulse_q     <= complete_w;

      if (complete_w) begin
        frame_q    <= shadow_d;
        frame_dp_q <= shadow_dp_d;
        valid_q    <= 1'b1;
        seen_q     <= '0;
      end else if (cap_w) begin
        seen_q <= seen_q | pos_w;
      end

      if (cap_w && invalid_w) err_q <= 1'b1;
      else if (clr_err)       err_q <= 1'b0;
    end
  end

  assign d0          = frame_q[3:0];
  assign d1          = frame_q[7:4];
  assign d2          = frame_q[11:8];
  assign d3          = frame_q[15:12];
  assign dp_mask     = frame_dp_q;
  assign frame_valid = valid_q;
  assign frame_pulse = pulse_q;
  assign seg_err     = err_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: directed scans plus random slots, checked against
// a slot/frame-level reference model of the display receiver.
module tb_seg_scan_capture;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       a = 0, b = 0, c = 0, d = 0, e = 0, f = 0, g = 0, dp = 0;
  logic [3:0] pos = 4'b0;
  logic       clr_err = 1'b0;
  logic [3:0] d0, d1, d2, d3, dp_mask;
  logic       frame_valid, frame_pulse, seg_err;

  always #5 clk = ~clk;

  seg_scan_capture #(.SETTLE(4), .SETTLE_BITS(4)) dut (
    .clk(clk), .reset(reset),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp),
    .pos(pos), .clr_err(clr_err),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .dp_mask(dp_mask),
    .frame_valid(frame_valid), .frame_pulse(frame_pulse), .seg_err(seg_err)
  );

  logic [6:0] pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                           7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  int checks = 0;
  int passed = 0;

  // Reference model: state of the display as seen at slot granularity.
  logic [3:0]  m_sh [4];
  logic [3:0]  m_shdp;
  logic [3:0]  m_seen;
  logic [3:0]  m_out [4];
  logic [3:0]  m_outdp;
  logic        m_valid, m_err;
  logic [11:0] m_last;
  int          pulse_at;

  function automatic logic [3:0] decode_ref(input logic [6:0] s);
    for (int k = 0; k < 10; k++) if (s == pat[k]) return 4'(k);
    if (s == 7'b0) return 4'hF;
    return 4'hE;
  endfunction

  function automatic int slot_of(input logic [3:0] p);
    int n = 0, idx = -1;
    for (int k = 0; k < 4; k++) if (p[k]) begin n++; idx = k; end
    return (n == 1) ? idx : -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin m_sh[k] = 4'hF; m_out[k] = 4'hF; end
    m_shdp = 0; m_seen = 0; m_outdp = 0; m_valid = 0; m_err = 0; m_last = 12'h0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "/d0"}, 32'(d0), 32'(m_out[0]));
    chk({tag, "/d1"}, 32'(d1), 32'(m_out[1]));
    chk({tag, "/d2"}, 32'(d2), 32'(m_out[2]));
    chk({tag, "/d3"}, 32'(d3), 32'(m_out[3]));
    chk({tag, "/dp_mask"}, 32'(dp_mask), 32'(m_outdp));
    chk({tag, "/frame_valid"}, 32'(frame_valid), 32'(m_valid));
    chk({tag, "/seg_err"}, 32'(seg_err), 32'(m_err));
  endtask

  task automatic drive(input logic [6:0] s, input logic dpv, input logic [3:0] pv);
    {a, b, c, d, e, f, g} = s;
    dp = dpv;
    pos = pv;
  endtask

  // Hold one slot for `hold` cycles (>= 10). A new, settled slot is sampled
  // 7 negedges after it is driven; clr_err pulses one cycle at index clr_at.
  task automatic scan_slot(input logic [6:0] s, input logic dpv, input logic [3:0] pv,
                           input int hold, input int clr_at, input string tag);
    logic [11:0] vec;
    logic [3:0]  code;
    int pulses = 0, slot, exp_pulses = 0;
    bit captured = 0;
    vec = {s, dpv, pv};
    drive(s, dpv, pv);
    pulse_at = -1;
    for (int k = 0; k < hold; k++) begin
      clr_err = (k == clr_at);
      @(negedge clk);
      if (frame_pulse) begin
        pulses++;
        if (pulse_at < 0) pulse_at = k + 1;
      end
    end
    clr_err = 1'b0;
    if (clr_at >= 0 && clr_at < 6) m_err = 0;
    if (vec != m_last) begin
      slot = slot_of(pv);
      if (slot >= 0) begin
        captured = 1;
        code = decode_ref(s);
        m_sh[slot] = code;
        m_shdp[slot] = dpv;
        if (code == 4'hE) m_err = 1;
        else if (clr_at == 6) m_err = 0;
        m_seen = m_seen | pv;
        if (m_seen == 4'hF) begin
          for (int k = 0; k < 4; k++) m_out[k] = m_sh[k];
          m_outdp = m_shdp; m_valid = 1; m_seen = 0; exp_pulses = 1;
        end
      end
    end
    if (!captured && clr_at == 6) m_err = 0;
    if (clr_at > 6) m_err = 0;
    m_last = vec;
    chk({tag, "/pulses"}, 32'(pulses), 32'(exp_pulses));
    chk_outputs(tag);
  endtask

  task automatic do_reset();
    scan_slot(7'b0, 1'b0, 4'b0, 10, -1, "pre_reset");
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int pulses;
    logic [6:0] s;
    logic [3:0] pv;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Reset state and idle
    chk("reset/frame_pulse", 32'(frame_pulse), 32'd0);
    chk_outputs("reset");
    pulses = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (frame_pulse) pulses++;
    end
    chk("idle/pulses", 32'(pulses), 32'd0);
    chk_outputs("idle");

    // Basic frame 5,9,0,2 with dp on slot 1
    scan_slot(pat[5], 1'b0, 4'b0001, 20, -1, "basic_s0");
    scan_slot(pat[9], 1'b1, 4'b0010, 20, -1, "basic_s1");
    scan_slot(pat[0], 1'b0, 4'b0100, 20, -1, "basic_s2");
    scan_slot(pat[2], 1'b0, 4'b1000, 20, -1, "basic_s3");
    chk("basic/pulse_latency", 32'(pulse_at), 32'd7);
    chk("basic/d0_lit", 32'(d0), 32'd5);
    chk("basic/d1_lit", 32'(d1), 32'd9);
    chk("basic/dp_lit", 32'(dp_mask), 32'b0010);

    // Glitching slot 0 ends the frame; only the settled value may appear
    scan_slot(pat[1], 1'b0, 4'b0010, 15, -1, "glitch_s1");
    scan_slot(pat[4], 1'b0, 4'b0100, 15, -1, "glitch_s2");
    scan_slot(pat[7], 1'b0, 4'b1000, 15, -1, "glitch_s3");
    pulses = 0;
    for (int t = 0; t < 10; t++) begin
      drive(7'b1111111 ^ 7'(t % 2), 1'b0, 4'b0001);
      repeat (3) begin
        @(negedge clk);
        if (frame_pulse) pulses++;
      end
    end
    m_last = {7'b1111110, 1'b0, 4'b0001};
    chk("glitch/no_pulse", 32'(pulses), 32'd0);
    scan_slot(pat[3], 1'b0, 4'b0001, 10, -1, "glitch_s0");
    chk("glitch/d0_lit", 32'(d0), 32'd3);

    // Illegal pattern on slot 2, then clears
    scan_slot(pat[6], 1'b1, 4'b0001, 12, -1, "ill_s0");
    scan_slot(pat[8], 1'b0, 4'b0010, 12, -1, "ill_s1");
    scan_slot(7'b1000001, 1'b0, 4'b0100, 12, -1, "ill_s2");
    scan_slot(pat[1], 1'b0, 4'b1000, 12, -1, "ill_s3");
    chk("ill/d2_lit", 32'(d2), 32'hE);
    chk("ill/err_lit", 32'(seg_err), 32'd1);
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0; m_err = 0;
    @(negedge clk);
    chk("ill/clr_alone", 32'(seg_err), 32'd0);
    scan_slot(7'b1000001, 1'b0, 4'b0100, 12, 6, "ill_coincide");
    chk("ill/set_wins", 32'(seg_err), 32'd1);

    // Multi-hot slot between legal slots
    scan_slot(pat[2], 1'b0, 4'b0001, 12, -1, "mh_s0");
    scan_slot(pat[8], 1'b0, 4'b0011, 20, -1, "mh_multi");
    scan_slot(pat[3], 1'b0, 4'b0100, 12, -1, "mh_s2");
    scan_slot(pat[4], 1'b1, 4'b1000, 12, -1, "mh_s3");
    scan_slot(pat[5], 1'b0, 4'b0010, 12, -1, "mh_s1");

    // Reset mid-frame discards partial state
    scan_slot(pat[1], 1'b0, 4'b0001, 12, -1, "rst_s0");
    scan_slot(pat[2], 1'b0, 4'b0010, 12, -1, "rst_s1");
    scan_slot(pat[3], 1'b0, 4'b0100, 12, -1, "rst_s2");
    do_reset();
    chk_outputs("after_reset");
    scan_slot(pat[4], 1'b0, 4'b1000, 12, -1, "post_s3");
    scan_slot(pat[6], 1'b0, 4'b0001, 12, -1, "post_s0");
    scan_slot(pat[7], 1'b0, 4'b0010, 12, -1, "post_s1");
    scan_slot(pat[9], 1'b1, 4'b0100, 12, -1, "post_s2");

    // Random slots
    for (int n = 0; n < 60; n++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 7)      s = pat[$urandom_range(0, 9)];
      else if (sel == 7) s = 7'b0;
      else              s = 7'($urandom);
      if ($urandom_range(0, 4) != 0) pv = 4'b0001 << $urandom_range(0, 3);
      else                           pv = 4'($urandom);
      scan_slot(s, 1'($urandom), pv, int'($urandom_range(10, 20)),
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 9)) : -1,
                $sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
